// File: rtl/sha1_mem_responder.sv
// sha1_mem_responder: memory-side responder for the SHA-1 accelerator.
// Serves word reads for the core and posts its digest writes into a small
// FIFO. That FIFO drains to the shared data RAM through a req/gnt port.
// Buffered writes always drain before a read is issued, so a read after a
// write to the same address always sees the new data.
module sha1_mem_responder #(
    parameter int RAM_LAT    = 1,
    parameter int WBUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_rd_req_i,
    input  logic [31:0] acc_addr_i,
    output logic [31:0] acc_rd_data_o,
    output logic        acc_rd_valid_o,
    input  logic        acc_wr_req_i,
    input  logic [31:0] acc_wr_data_i,
    output logic        acc_wr_ack_o,
    output logic        acc_busy_o,
    output logic        ram_req_o,
    input  logic        ram_gnt_i,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        WR_DRAIN,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] buf_addr [WBUF_DEPTH];
    logic [31:0] buf_data [WBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        full;
    logic        push;
    logic        pop;
    logic        rd_start;
    logic        rd_grant;
    logic        capture;
    logic [31:0] rd_addr;
    logic [2:0]  lat_cnt;

    // A granted drain frees a slot in the same cycle, so a full buffer can
    // still accept a word while it is popping.
    assign full         = (count == CNT_W'(WBUF_DEPTH));
    assign push         = acc_wr_req_i && (!full || pop);
    assign acc_wr_ack_o = push;
    assign acc_busy_o   = (count != '0) || (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and RAM port drive; RAM outputs depend only on state and
    // registered values, so they stay stable while gnt is low
    always_comb begin
        next_state  = state;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = 32'h0;
        pop         = 1'b0;
        rd_start    = 1'b0;
        rd_grant    = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    next_state = WR_DRAIN;
                end else if (acc_rd_req_i && !acc_rd_valid_o) begin
                    next_state = RD_ISSUE;
                    rd_start   = 1'b1;
                end
            end
            WR_DRAIN: begin
                ram_req_o   = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = buf_addr[rd_ptr] & WORD_MASK;
                ram_wdata_o = buf_data[rd_ptr];
                if (ram_gnt_i) begin
                    pop = 1'b1;
                    if (count == CNT_W'(1) && !acc_wr_req_i) begin
                        next_state = IDLE;
                    end
                end
            end
            RD_ISSUE: begin
                ram_req_o  = 1'b1;
                ram_addr_o = rd_addr;
                if (ram_gnt_i) begin
                    rd_grant   = 1'b1;
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt == 3'd1) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write buffer pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Write buffer storage; contents are meaningless while count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= acc_addr_i;
            buf_data[wr_ptr] <= acc_wr_data_i;
        end
    end

    // Read path: latch the address, count down the RAM latency, capture data
    // on the last wait cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr        <= 32'h0;
            lat_cnt        <= 3'd0;
            acc_rd_data_o  <= 32'h0;
            acc_rd_valid_o <= 1'b0;
        end else begin
            acc_rd_valid_o <= capture;
            if (rd_start) begin
                rd_addr <= acc_addr_i & WORD_MASK;
            end
            if (rd_grant) begin
                lat_cnt <= 3'(RAM_LAT);
            end else if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (capture) begin
                acc_rd_data_o <= ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_sha1_mem_responder.sv
// Directed bench for sha1_mem_responder with a simple RAM model behind the
// req/gnt port (RAM_LAT = 1, WBUF_DEPTH = 8).
module tb_sha1_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        acc_rd_req_i = 1'b0;
    logic [31:0] acc_addr_i = 32'h0;
    logic [31:0] acc_rd_data_o;
    logic        acc_rd_valid_o;
    logic        acc_wr_req_i = 1'b0;
    logic [31:0] acc_wr_data_i = 32'h0;
    logic        acc_wr_ack_o;
    logic        acc_busy_o;
    logic        ram_req_o;
    logic        ram_gnt_i = 1'b1;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = 32'h0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [16384];
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    int wr_n = 0;
    int ops = 0;
    int last_wr_seq = 0;
    int last_rd_seq = 0;

    sha1_mem_responder #(.RAM_LAT(1), .WBUF_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .acc_rd_req_i   (acc_rd_req_i),
        .acc_addr_i     (acc_addr_i),
        .acc_rd_data_o  (acc_rd_data_o),
        .acc_rd_valid_o (acc_rd_valid_o),
        .acc_wr_req_i   (acc_wr_req_i),
        .acc_wr_data_i  (acc_wr_data_i),
        .acc_wr_ack_o   (acc_wr_ack_o),
        .acc_busy_o     (acc_busy_o),
        .ram_req_o      (ram_req_o),
        .ram_gnt_i      (ram_gnt_i),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // RAM model: preload the test word, log granted writes, return read data
    // one cycle after the granted read
    always @(posedge clk) begin
        if (!rst) begin
            mem[14'h0400] <= 32'h3132_3334;
        end else if (ram_req_o && ram_gnt_i) begin
            ops <= ops + 1;
            if (ram_we_o) begin
                mem[ram_addr_o[15:2]] <= ram_wdata_o;
                log_addr[wr_n] <= ram_addr_o;
                log_data[wr_n] <= ram_wdata_o;
                wr_n <= wr_n + 1;
                last_wr_seq <= ops + 1;
            end else begin
                ram_rdata_i <= mem[ram_addr_o[15:2]];
                last_rd_seq <= ops + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        acc_rd_req_i  = rd;
        acc_wr_req_i  = wr;
        acc_addr_i    = addr;
        acc_wr_data_i = data;
    endtask

    // Step until the read completes or the budget runs out; lat counts cycles
    task automatic waitValid(input int budget, inout int lat);
        int n;
        n = 0;
        while (!acc_rd_valid_o && n < budget) begin
            step();
            lat++;
            n++;
        end
        checkOutput("rd_valid_timeout", {31'h0, acc_rd_valid_o}, 32'h1);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (acc_busy_o && n < budget) begin
            step();
            n++;
        end
        checkOutput("busy_timeout", {31'h0, acc_busy_o}, 32'h0);
    endtask

    initial begin
        int lat;
        int base;
        int n;

        // Reset state
        #2;
        checkOutput("rst_ram_req", {31'h0, ram_req_o}, 32'h0);
        checkOutput("rst_ram_we", {31'h0, ram_we_o}, 32'h0);
        checkOutput("rst_ram_addr", ram_addr_o, 32'h0);
        checkOutput("rst_ram_wdata", ram_wdata_o, 32'h0);
        checkOutput("rst_rd_data", acc_rd_data_o, 32'h0);
        checkOutput("rst_rd_valid", {31'h0, acc_rd_valid_o}, 32'h0);
        checkOutput("rst_busy", {31'h0, acc_busy_o}, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();

        // Test 1: basic read, immediate grant
        $display("[TB] test 1 read");
        applyStimulus(1'b1, 1'b0, 32'h1000_1000, 32'h0);
        lat = 0;
        step();
        lat++;
        checkOutput("t1_ram_req", {31'h0, ram_req_o}, 32'h1);
        checkOutput("t1_ram_we", {31'h0, ram_we_o}, 32'h0);
        checkOutput("t1_ram_addr", ram_addr_o, 32'h1000_1000);
        waitValid(20, lat);
        checkOutput("t1_latency", lat, 32'd3);
        checkOutput("t1_rd_data", acc_rd_data_o, 32'h3132_3334);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("t1_valid_pulse", {31'h0, acc_rd_valid_o}, 32'h0);
        checkOutput("t1_data_held", acc_rd_data_o, 32'h3132_3334);
        checkOutput("t1_ram_req_idle", {31'h0, ram_req_o}, 32'h0);

        // Test 2: five back-to-back digest writes
        $display("[TB] test 2 writes");
        base = wr_n;
        applyStimulus(1'b0, 1'b1, 32'h1000_2000, 32'h6745_2301);
        #1 checkOutput("t2_ack0", {31'h0, acc_wr_ack_o}, 32'h1);
        step();
        applyStimulus(1'b0, 1'b1, 32'h1000_2004, 32'hEFCD_AB89);
        #1 checkOutput("t2_ack1", {31'h0, acc_wr_ack_o}, 32'h1);
        step();
        applyStimulus(1'b0, 1'b1, 32'h1000_2008, 32'h98BA_DCFE);
        #1 checkOutput("t2_ack2", {31'h0, acc_wr_ack_o}, 32'h1);
        step();
        applyStimulus(1'b0, 1'b1, 32'h1000_200C, 32'h1032_5476);
        #1 checkOutput("t2_ack3", {31'h0, acc_wr_ack_o}, 32'h1);
        step();
        applyStimulus(1'b0, 1'b1, 32'h1000_2010, 32'hC3D2_E1F0);
        #1 checkOutput("t2_ack4", {31'h0, acc_wr_ack_o}, 32'h1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t2_busy_draining", {31'h0, acc_busy_o}, 32'h1);
        waitIdle(40);
        checkOutput("t2_write_count", wr_n - base, 32'd5);
        checkOutput("t2_addr0", log_addr[base], 32'h1000_2000);
        checkOutput("t2_data0", log_data[base], 32'h6745_2301);
        checkOutput("t2_addr2", log_addr[base+2], 32'h1000_2008);
        checkOutput("t2_data3", log_data[base+3], 32'h1032_5476);
        checkOutput("t2_addr4", log_addr[base+4], 32'h1000_2010);
        checkOutput("t2_data4", log_data[base+4], 32'hC3D2_E1F0);

        // Test 3: write then immediate read of the same address
        $display("[TB] test 3 read-after-write");
        applyStimulus(1'b0, 1'b1, 32'h1000_2000, 32'hCAFE_F00D);
        step();
        applyStimulus(1'b1, 1'b0, 32'h1000_2000, 32'h0);
        lat = 0;
        waitValid(20, lat);
        checkOutput("t3_rd_data", acc_rd_data_o, 32'hCAFE_F00D);
        checkOutput("t3_wr_before_rd", {31'h0, (last_wr_seq < last_rd_seq)}, 32'h1);
        checkOutput("t3_wr_addr", log_addr[wr_n-1], 32'h1000_2000);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Test 4: grant withheld for 4 cycles in RD_ISSUE, unaligned address
        $display("[TB] test 4 read stall");
        ram_gnt_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h1000_1002, 32'h0);
        lat = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            lat++;
            checkOutput("t4_stall_req", {31'h0, ram_req_o}, 32'h1);
            checkOutput("t4_stall_we", {31'h0, ram_we_o}, 32'h0);
            checkOutput("t4_stall_addr", ram_addr_o, 32'h1000_1000);
            checkOutput("t4_stall_wdata", ram_wdata_o, 32'h0);
            checkOutput("t4_stall_valid", {31'h0, acc_rd_valid_o}, 32'h0);
        end
        ram_gnt_i = 1'b1;
        waitValid(20, lat);
        checkOutput("t4_latency", lat, 32'd7);
        checkOutput("t4_rd_data", acc_rd_data_o, 32'h3132_3334);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Test 5: fill the buffer with grant low, then push+pop on a full buffer
        $display("[TB] test 5 full buffer");
        base = wr_n;
        ram_gnt_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h1000_3000 + 32'(4 * k), 32'hA000_0000 + 32'(k));
            #1 checkOutput("t5_ack_fill", {31'h0, acc_wr_ack_o}, 32'h1);
            step();
        end
        applyStimulus(1'b0, 1'b1, 32'h1000_3020, 32'hA000_0008);
        #1;
        checkOutput("t5_ack_full", {31'h0, acc_wr_ack_o}, 32'h0);
        checkOutput("t5_head_addr", ram_addr_o, 32'h1000_3000);
        checkOutput("t5_head_we", {31'h0, ram_we_o}, 32'h1);
        step();
        checkOutput("t5_ack_still_full", {31'h0, acc_wr_ack_o}, 32'h0);
        checkOutput("t5_no_write", wr_n - base, 32'd0);
        ram_gnt_i = 1'b1;
        #1 checkOutput("t5_ack_push_pop", {31'h0, acc_wr_ack_o}, 32'h1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        waitIdle(40);
        checkOutput("t5_write_count", wr_n - base, 32'd9);
        checkOutput("t5_first_addr", log_addr[base], 32'h1000_3000);
        checkOutput("t5_last_addr", log_addr[base+8], 32'h1000_3020);
        checkOutput("t5_last_data", log_data[base+8], 32'hA000_0008);
        checkOutput("t5_mid_data", log_data[base+5], 32'hA000_0005);

        // Test 6: reset in the middle of a drain
        $display("[TB] test 6 reset mid-drain");
        base = wr_n;
        ram_gnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 32'h1000_4000 + 32'(4 * k), 32'hB000_0000 + 32'(k));
            step();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        ram_gnt_i = 1'b1;
        n = 0;
        while ((wr_n - base) < 3 && n < 20) begin
            step();
            n++;
        end
        checkOutput("t6_three_written", wr_n - base, 32'd3);
        rst = 1'b0;
        #1;
        checkOutput("t6_ram_req", {31'h0, ram_req_o}, 32'h0);
        checkOutput("t6_ram_we", {31'h0, ram_we_o}, 32'h0);
        checkOutput("t6_ram_addr", ram_addr_o, 32'h0);
        checkOutput("t6_ram_wdata", ram_wdata_o, 32'h0);
        checkOutput("t6_busy", {31'h0, acc_busy_o}, 32'h0);
        checkOutput("t6_rd_data", acc_rd_data_o, 32'h0);
        checkOutput("t6_rd_valid", {31'h0, acc_rd_valid_o}, 32'h0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
        end
        checkOutput("t6_no_more_writes", wr_n - base, 32'd3);
        checkOutput("t6_busy_after", {31'h0, acc_busy_o}, 32'h0);
        checkOutput("t6_req_after", {31'h0, ram_req_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
